// File: rtl/matrix_pkg.sv
// Shared dimensions, result-width helper and output FSM states for the matrix multiplier datapath.
package matrix_pkg;

  localparam int unsigned DATA_WIDTH       = 8;
  localparam int unsigned A_ROWS           = 8;
  localparam int unsigned B_COLUMNS        = 5;
  localparam int unsigned A_COLUMNS_B_ROWS = 4;

  // Product of two operands plus growth from summing `inner` partial products.
  function automatic int unsigned c_data_width(input int unsigned data_width,
                                               input int unsigned inner);
    return 2 * data_width + $clog2(inner);
  endfunction

  typedef enum logic {
    StIdle,
    StStream
  } out_state_e;

endpackage

// File: rtl/matrix_result_bank.sv
// One ping-pong bank: a full matrix of result registers, its occupancy flag and a read mux.
module matrix_result_bank
  import matrix_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 40,
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] wdata [DEPTH],
  input  logic             clear,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      if (load) begin
        mem_q <= wdata;
      end
      // A reload in the same cycle as the drain of this bank keeps it occupied.
      if (load) begin
        full_q <= 1'b1;
      end else if (clear) begin
        full_q <= 1'b0;
      end
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign full    = full_q;

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures whole result matrices into two alternating banks and streams them out element by
// element in row-major order over valid/ready, dropping and counting matrices when both are full.
module matrix_result_serializer #(
  parameter int unsigned C_DATA_WIDTH   = matrix_pkg::c_data_width(matrix_pkg::DATA_WIDTH,
                                                                   matrix_pkg::A_COLUMNS_B_ROWS),
  parameter int unsigned A_ROWS         = matrix_pkg::A_ROWS,
  parameter int unsigned B_COLUMNS      = matrix_pkg::B_COLUMNS,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  localparam int unsigned N             = A_ROWS * B_COLUMNS,
  localparam int unsigned ROW_W         = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
  localparam int unsigned COL_W         = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1,
  localparam int unsigned IDX_W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  input  logic [C_DATA_WIDTH-1:0]   c_i [N],
  output logic                      ready_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [C_DATA_WIDTH-1:0]   data_o,
  output logic [ROW_W-1:0]          row_o,
  output logic [COL_W-1:0]          col_o,
  output logic                      last_o,
  output logic                      overrun_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
  import matrix_pkg::*;

  out_state_e                state_q, state_d;
  logic                      wr_bank_q, rd_bank_q;
  logic [IDX_W-1:0]          idx_q;
  logic [ROW_W-1:0]          row_q;
  logic [COL_W-1:0]          col_q;
  logic                      overrun_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  logic [1:0]              full, load, clear;
  logic [C_DATA_WIDTH-1:0] rd_data [2];
  logic                    xfer, at_last, rel, wr_free, capture, overrun;

  assign xfer    = (state_q == StStream) && ready_i;
  assign at_last = (idx_q == IDX_W'(N - 1));
  assign rel     = xfer && at_last;
  // Banks fill in order, so the write bank is the only candidate; it may be the one draining now.
  assign wr_free = !full[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
  assign capture = valid_i && wr_free;
  assign overrun = valid_i && !wr_free;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign load[b]  = capture && (wr_bank_q == 1'(b));
    assign clear[b] = rel && (rd_bank_q == 1'(b));

    matrix_result_bank #(
      .WIDTH (C_DATA_WIDTH),
      .DEPTH (N)
    ) u_bank (
      .clk     (clk_i),
      .reset   (reset_i),
      .load    (load[b]),
      .wdata   (c_i),
      .clear   (clear[b]),
      .rd_idx  (idx_q),
      .rd_data (rd_data[b]),
      .full    (full[b])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StStream;
        end
      end
      StStream: begin
        // Continue straight into the other bank if it holds, or is receiving, a matrix.
        if (rel) begin
          state_d = (full[!rd_bank_q] || load[!rd_bank_q]) ? StStream : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun;
      if (capture) begin
        wr_bank_q <= !wr_bank_q;
      end
      if (xfer) begin
        if (at_last) begin
          idx_q     <= '0;
          row_q     <= '0;
          col_q     <= '0;
          rd_bank_q <= !rd_bank_q;
        end else begin
          idx_q <= idx_q + 1'b1;
          if (col_q == COL_W'(B_COLUMNS - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
      end
      if (overrun && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign valid_o    = (state_q == StStream);
  assign data_o     = rd_data[rd_bank_q];
  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_o     = at_last;
  assign overrun_o  = overrun_q;
  assign drop_cnt_o = drop_cnt_q;
  assign ready_o    = !(full[0] && full[1]);

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench: a queue-of-matrices model checked every cycle, plus literal beat-log checks.
module tb_matrix_result_serializer;

  localparam int W  = 18;
  localparam int AR = 8;
  localparam int BC = 5;
  localparam int N  = AR * BC;

  logic          clk = 1'b0;
  logic          reset_i, valid_i, ready_i;
  logic [W-1:0]  c_i [N];
  logic          ready_o, valid_o, last_o, overrun_o;
  logic [W-1:0]  data_o;
  logic [2:0]    row_o, col_o;
  logic [15:0]   drop_cnt_o;
  logic          s_ready, s_valid, s_last, s_overrun;
  logic [W-1:0]  s_data;
  logic [2:0]    s_row, s_col;
  logic [1:0]    s_drop;

  always #5 clk = ~clk;

  matrix_result_serializer dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .c_i(c_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .row_o(row_o), .col_o(col_o),
    .last_o(last_o), .overrun_o(overrun_o), .drop_cnt_o(drop_cnt_o)
  );

  // Narrow drop counter so saturation is reachable in a few cycles.
  matrix_result_serializer #(.DROP_CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .c_i(c_i), .ready_o(s_ready),
    .valid_o(s_valid), .ready_i(ready_i), .data_o(s_data), .row_o(s_row), .col_o(s_col),
    .last_o(s_last), .overrun_o(s_overrun), .drop_cnt_o(s_drop)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO of buffered matrices (identified by base; element k = base+k+1).
  int mq[$];
  int m_idx = 0;
  int m_drop = 0;
  bit m_ovr = 1'b0;
  int cur_base = 0;

  always @(posedge clk) begin
    bit xf, rl;
    int occ;
    if (reset_i) begin
      mq.delete();
      m_idx = 0;
      m_drop = 0;
      m_ovr = 1'b0;
    end else begin
      xf = (mq.size() > 0) && ready_i;
      rl = xf && (m_idx == N - 1);
      occ = mq.size() - (rl ? 1 : 0);
      m_ovr = 1'b0;
      if (xf) begin
        if (rl) begin
          void'(mq.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (valid_i) begin
        if (occ < 2) mq.push_back(cur_base);
        else begin
          m_ovr = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  typedef struct {int d; int r; int c; bit l;} beat_t;
  beat_t beats[$];
  int    ovr_seen = 0;
  bit    checking = 1'b0;

  always @(negedge clk) begin
    if (checking) begin
      chk("valid_o", valid_o, mq.size() > 0);
      chk("ready_o", ready_o, mq.size() < 2);
      chk("overrun_o", overrun_o, m_ovr);
      chk("drop_cnt_o", drop_cnt_o, m_drop);
      chk("last_o", last_o, (mq.size() > 0) && (m_idx == N - 1));
      chk("sat_drop", s_drop, (m_drop > 3) ? 3 : m_drop);
      chk("sat_overrun", s_overrun, m_ovr);
      if (mq.size() > 0) begin
        chk("data_o", data_o, mq[0] + m_idx + 1);
        chk("row_o", row_o, m_idx / BC);
        chk("col_o", col_o, m_idx % BC);
      end
      if (valid_o && ready_i && !reset_i) beats.push_back('{int'(data_o), int'(row_o),
                                                            int'(col_o), last_o});
      if (overrun_o) ovr_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_c(input int base);
    cur_base = base;
    for (int k = 0; k < N; k++) c_i[k] = W'(base + k + 1);
  endtask

  task automatic send(input int base);
    load_c(base);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (mq.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    if (mq.size() > 0) chk("drain_timeout", mq.size(), 0);
    tick();
  endtask

  task automatic wait_idx(input int target, input int limit);
    int n = 0;
    while (!(mq.size() > 0 && m_idx == target) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) chk("wait_idx_timeout", m_idx, target);
  endtask

  initial begin
    int bad, nlast, ov0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    load_c(0);
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", data_o, 0);
    chk("rst_rowcol", {row_o, col_o}, 0);
    chk("rst_last", last_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    checking = 1'b1;

    // Single matrix, ready held high.
    ready_i = 1'b1;
    beats.delete();
    send(0);
    chk("latency_valid", valid_o, 1);
    drain(100);
    chk("t1_beats", beats.size(), 40);
    if (beats.size() == 40) begin
      chk("t1_first", beats[0].d, 1);
      chk("t1_lastd", beats[39].d, 40);
      chk("t1_last_row", beats[39].r, 7);
      chk("t1_last_col", beats[39].c, 4);
      chk("t1_row_b6", beats[6].r, 1);
      chk("t1_col_b6", beats[6].c, 1);
      nlast = 0;
      foreach (beats[i]) if (beats[i].l) nlast++;
      chk("t1_one_last", nlast, 1);
      chk("t1_last_flag", beats[39].l, 1);
    end
    chk("t1_idle", valid_o, 0);

    // Backpressure pattern 1,0,0,1.
    beats.delete();
    send(100);
    for (int i = 0; i < 400 && mq.size() > 0; i++) begin
      ready_i = (i % 4 == 0 || i % 4 == 3);
      tick();
    end
    ready_i = 1'b1;
    drain(100);
    chk("t2_beats", beats.size(), 40);
    bad = 0;
    foreach (beats[i]) if (beats[i].d != 100 + i + 1) bad++;
    chk("t2_order", bad, 0);

    // Three back-to-back matrices with downstream stalled: the third is dropped.
    ready_i = 1'b0;
    ov0 = ovr_seen;
    for (int j = 0; j < 3; j++) begin
      load_c(200 + 100 * j);
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    tick();
    tick();
    chk("t3_drop", drop_cnt_o, 1);
    chk("t3_ready", ready_o, 0);
    chk("t3_pulses", ovr_seen - ov0, 1);
    beats.delete();
    ready_i = 1'b1;
    drain(200);
    chk("t3_beats", beats.size(), 80);
    if (beats.size() == 80) begin
      chk("t3_m1", beats[0].d, 201);
      chk("t3_m2", beats[40].d, 301);
      chk("t3_end", beats[79].d, 340);
    end

    // Last beat released in the same cycle a new matrix arrives with both banks full.
    ready_i = 1'b0;
    send(500);
    send(600);
    chk("t4_full", ready_o, 0);
    ov0 = ovr_seen;
    beats.delete();
    ready_i = 1'b1;
    wait_idx(N - 1, 100);
    send(700);
    drain(200);
    chk("t4_drop", drop_cnt_o, 1);
    chk("t4_pulses", ovr_seen - ov0, 0);
    chk("t4_beats", beats.size(), 120);
    if (beats.size() == 120) begin
      chk("t4_m2", beats[40].d, 601);
      chk("t4_m3", beats[80].d, 701);
      chk("t4_end", beats[119].d, 740);
    end

    // Reset at beat 17 with a second matrix buffered; valid_i during reset is ignored.
    ready_i = 1'b0;
    send(800);
    send(900);
    ready_i = 1'b1;
    wait_idx(16, 100);
    reset_i = 1'b1;
    load_c(1100);
    valid_i = 1'b1;
    tick();
    reset_i = 1'b0;
    valid_i = 1'b0;
    chk("t5_valid", valid_o, 0);
    chk("t5_drop", drop_cnt_o, 0);
    chk("t5_ready", ready_o, 1);
    beats.delete();
    send(1000);
    drain(100);
    chk("t5_beats", beats.size(), 40);
    if (beats.size() == 40) begin
      chk("t5_first", beats[0].d, 1001);
      chk("t5_first_rc", beats[0].r + beats[0].c, 0);
    end

    // Five overruns: wide counter reaches 5, narrow one sticks at all-ones.
    ready_i = 1'b0;
    send(1200);
    send(1300);
    ov0 = ovr_seen;
    load_c(1400);
    valid_i = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    valid_i = 1'b0;
    tick();
    chk("t6_drop", drop_cnt_o, 5);
    chk("t6_sat", s_drop, 3);
    chk("t6_pulses", ovr_seen - ov0, 5);
    beats.delete();
    ready_i = 1'b1;
    drain(200);
    chk("t6_beats", beats.size(), 80);
    if (beats.size() == 80) chk("t6_m2", beats[40].d, 1301);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
